// File: rtl/syscall_uart_tx_pkg.sv
// Shared encodings for the syscall console UART transmitter.
// Pure declarations; no logic, no latency, no backpressure.
package syscall_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam int   FRAME_BITS    = 10;

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through head and explicit level counter.
// Latency: a pushed byte is visible at o_data one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_byte_fifo #(
    parameter int DEPTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [7:0]            i_data,
    output logic [7:0]            o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level
);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  push_ok, pop_ok;

    assign o_full  = (level_q == (DEPTH_LOG2+1)'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_data  = mem_q[rd_ptr_q];

    // Full/empty are the pre-edge view, so a push while full is dropped even if a pop happens too.
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok && !i_rst) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/syscall_uart_tx.sv
// Syscall putchar sink: byte FIFO drained by an 8N1 UART serialiser on o_tx.
// Latency: byte written into an idle empty block starts its start bit one cycle later.
// Backpressure: none (writer cannot stall); writes while full are dropped and set sticky o_ovf.
module syscall_uart_tx
    import syscall_uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DEPTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [7:0]            i_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_ovf
);

    localparam int             BW          = $clog2(CLK_DIV);
    localparam logic [BW-1:0]  BAUD_RELOAD = BW'(CLK_DIV - 1);

    uart_state_e    state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           ovf_q, ovf_d;
    logic           pop;
    logic [7:0]     fifo_head;
    logic           fifo_full, fifo_empty;

    sync_byte_fifo #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_we),
        .i_pop   (pop),
        .i_data  (i_data),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (o_level)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        ovf_d   = ovf_q | (i_we & fifo_full);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    tx_d    = 1'b0;
                    baud_d  = BAUD_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    baud_d  = BAUD_RELOAD;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = UART_IDLE_LVL;
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more bytes are waiting.
                if (baud_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        tx_d    = 1'b0;
                        baud_d  = BAUD_RELOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LVL;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_full  = fifo_full;
    assign o_empty = fifo_empty;
    assign o_tx    = tx_q;
    assign o_ovf   = ovf_q;
    assign o_busy  = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_syscall_uart_tx.sv
// Randomised bench: frame-level FIFO/transmitter model feeds a queue of expected bytes,
// and a serial-line decoder pops and compares each received frame.
module tb_syscall_uart_tx;
    import syscall_uart_tx_pkg::*;

    localparam int CD    = 4;
    localparam int DEPTH = 16;
    localparam int DL2   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, we = 1'b0;
    logic [7:0]   data = 8'h00;
    logic         o_full, o_empty, o_tx, o_busy, o_ovf;
    logic [DL2:0] o_level;

    logic         rst2 = 1'b1, we2 = 1'b0;
    logic [7:0]   data2 = 8'h00;
    logic         full2, empty2, tx2, busy2, ovf2;
    logic [DL2:0] level2;

    syscall_uart_tx #(.CLK_DIV(CD), .DEPTH(DEPTH), .DEPTH_LOG2(DL2)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_we(we), .i_data(data),
        .o_full(o_full), .o_empty(o_empty), .o_level(o_level),
        .o_tx(o_tx), .o_busy(o_busy), .o_ovf(o_ovf)
    );

    syscall_uart_tx #(.CLK_DIV(2), .DEPTH(DEPTH), .DEPTH_LOG2(DL2)) u_dut2 (
        .i_clk(clk), .i_rst(rst2), .i_we(we2), .i_data(data2),
        .o_full(full2), .o_empty(empty2), .o_level(level2),
        .o_tx(tx2), .o_busy(busy2), .o_ovf(ovf2)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model: bytes waiting in the FIFO, bytes handed to the line, and the earliest edge
    // at which the transmitter may take another byte (one pop per FRAME_BITS*CD cycles).
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         next_pop = 0;
    logic       m_ovf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic w, input logic [7:0] d);
        bit pre_full;
        if (r) begin
            mq.delete();
            exp_q.delete();
            next_pop = 0;
            m_ovf = 1'b0;
        end else begin
            pre_full = (mq.size() == DEPTH);
            if (mq.size() > 0 && edge_n >= next_pop) begin
                exp_q.push_back(mq.pop_front());
                next_pop = edge_n + FRAME_BITS * CD;
            end
            if (w) begin
                if (pre_full) m_ovf = 1'b1;
                else          mq.push_back(d);
            end
        end
    endtask

    task automatic tick(input logic r, input logic w, input logic [7:0] d);
        int busy_m;
        rst = r; we = w; data = d;
        @(posedge clk);
        edge_n++;
        model_edge(r, w, d);
        #1;
        busy_m = (mq.size() > 0 || edge_n < next_pop) ? 1 : 0;
        chk("level", int'(o_level), mq.size());
        chk("full", int'(o_full), (mq.size() == DEPTH) ? 1 : 0);
        chk("empty", int'(o_empty), (mq.size() == 0) ? 1 : 0);
        chk("busy", int'(o_busy), busy_m);
        chk("ovf", int'(o_ovf), int'(m_ovf));
        if (busy_m == 0) chk("tx_idle", int'(o_tx), 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() > 0 || edge_n < next_pop) && n < 2000) begin
            tick(1'b0, 1'b0, 8'h00);
            n++;
        end
        chk("drain_timeout", (n < 2000) ? 1 : 0, 1);
        repeat (3) tick(1'b0, 1'b0, 8'h00);
    endtask

    // Serial decoder: samples mid-bit, LSB first, and checks each byte against the model.
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    always @(negedge clk) begin
        int bitn;
        if (rst) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act && o_tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end else if (mon_act) begin
                mon_cnt++;
            end
            if (mon_act && (mon_cnt % CD) == CD / 2) begin
                bitn = mon_cnt / CD;
                if (bitn == 0) begin
                    chk("start_bit", int'(o_tx), 0);
                end else if (bitn <= 8) begin
                    mon_byte[bitn-1] = o_tx;
                end else begin
                    chk("stop_bit", int'(o_tx), 1);
                    chk("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) chk("rx_byte", int'(mon_byte), int'(exp_q.pop_front()));
                    mon_act = 1'b0;
                end
            end
        end
    end

    initial begin
        int sent;
        // Reset and single 'A'
        repeat (2) tick(1'b1, 1'b0, 8'h00);
        chk("rst_tx", int'(o_tx), 1);
        chk("rst_empty", int'(o_empty), 1);
        repeat (7) tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h41);
        drain();

        // Back-to-back
        tick(1'b0, 1'b1, 8'h55);
        tick(1'b0, 1'b1, 8'hAA);
        drain();

        // Overflow: 18 consecutive writes from idle
        for (int i = 0; i < 18; i++) tick(1'b0, 1'b1, 8'($urandom));
        chk("ovf_after_18", int'(o_ovf), 1);
        chk("full_after_18", int'(o_full), 1);
        drain();
        chk("ovf_sticky", int'(o_ovf), 1);

        // Wrap-around: 0..39 written only when the model says there is room
        tick(1'b1, 1'b0, 8'h00);
        sent = 0;
        while (sent < 40) begin
            if (mq.size() < DEPTH && $urandom_range(3) != 0) begin
                tick(1'b0, 1'b1, 8'(sent));
                sent++;
            end else begin
                tick(1'b0, 1'b0, 8'h00);
            end
        end
        drain();
        chk("ovf_wrap", int'(o_ovf), 0);

        // Random traffic, overflow allowed
        for (int i = 0; i < 250; i++) tick(1'b0, ($urandom_range(3) == 0), 8'($urandom));
        drain();

        // Reset during DATA bit 3 with 5 bytes queued
        tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 8'($urandom));
        repeat (13) tick(1'b0, 1'b0, 8'h00);
        chk("pre_rst_level", int'(o_level), 5);
        tick(1'b1, 1'b0, 8'h00);
        chk("mid_rst_tx", int'(o_tx), 1);
        chk("mid_rst_level", int'(o_level), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_ovf", int'(o_ovf), 0);
        tick(1'b0, 1'b1, 8'h7E);
        drain();
        chk("exp_q_empty", exp_q.size(), 0);
        chk("mon_idle", int'(mon_act), 0);

        // CLK_DIV=2 instance: single 0xFF
        @(posedge clk); #1;
        rst2 = 1'b0; we2 = 1'b1; data2 = 8'hFF;
        @(posedge clk); #1;
        we2 = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            chk("tx_div2", int'(tx2), (i < 2) ? 0 : 1);
            chk("busy_div2", int'(busy2), (i < 20) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/syscall_uart_tx.md
Name: syscall_uart_tx

Overview:
- Console output stage directly downstream of the processor's syscall unit.
- The syscall "putchar" path writes one byte per strobe into an internal byte FIFO.
- A UART transmitter drains the FIFO and serialises each byte as 8N1 on o_tx.
- The processor is single-cycle and cannot stall. Software polls o_full via a status syscall. Bytes written while the FIFO is full are dropped and flagged.

Parameters:
- CLK_DIV, 16: clock cycles per UART bit; legal range is 2 or more.
- DEPTH, 16: FIFO entries; must be a power of 2.
- DEPTH_LOG2, 4: log2(DEPTH).

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_we  in  1  write strobe from syscall putchar; one byte per asserted cycle.
- i_data  in  8  byte to transmit.
- o_full  out  1  FIFO holds DEPTH entries.
- o_empty  out  1  FIFO holds 0 entries.
- o_level  out  DEPTH_LOG2+1  FIFO occupancy. Excludes the byte currently in the shifter.
- o_tx  out  1  serial line; idles high.
- o_busy  out  1  equals !o_empty OR (state != IDLE).
- o_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (i_rst high at a clock edge) sets:
  - FIFO pointers and level to 0, so o_empty=1 and o_full=0.
  - state=IDLE and o_tx=1.
  - o_busy=0 and o_ovf=0.
  - baud counter and bit index to 0.
- Reset mid-frame aborts the frame; o_tx is 1 from the next cycle. Reset overrides a write in the same cycle.
- FIFO write:
  - A write is accepted when i_we=1 and o_full=0 (registered value at that edge).
  - If i_we=1 and o_full=1, the byte is dropped, level is unchanged, and o_ovf is set to 1. o_ovf stays 1 until reset.
  - A write while full is dropped even when a pop occurs in the same cycle. o_full reflects the pre-edge state.
- Simultaneous write and pop when not full: level is unchanged, both pointers advance, data order is preserved.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Level is tracked by a separate counter of width DEPTH_LOG2+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty, pop the head into an 8-bit shifter, set o_tx=0, load baud counter with CLK_DIV-1, go to START.
  - START: hold o_tx=0 until the baud counter reaches 0. Then set o_tx=shift[0], bit index=0, go to DATA.
  - DATA: on each baud expiry, shift right and increment the bit index. After bit 7 expires, set o_tx=1 and go to STOP.
  - STOP: hold o_tx=1 for CLK_DIV cycles. At expiry, if FIFO is non-empty, pop and go directly to START with o_tx=0 (no idle gap). Otherwise go to IDLE.
- o_tx is driven from a flop; there is no combinational path from i_data.
- Latency: byte written at edge k while IDLE and empty:
  - o_tx falls at edge k+1.
  - Each bit lasts exactly CLK_DIV cycles, data LSB first.
  - The frame is 10*CLK_DIV cycles.
  - The next back-to-back start bit begins at edge k+1+10*CLK_DIV.
- o_level decrements on the pop edge; a byte in flight is not counted.
- The baud counter is $clog2(CLK_DIV) bits, counts down, and reloads with CLK_DIV-1 at each bit boundary.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - UART_IDLE_LVL=1'b1;
  - FRAME_BITS=10.
- Sub-module sync_byte_fifo(i_clk, i_rst, i_push, i_pop, i_data, o_data, o_full, o_empty, o_level):
  - parameterised by DEPTH and DEPTH_LOG2;
  - head data is available combinationally (first-word fall-through).
- syscall_uart_tx owns the FSM, baud counter, shifter and overflow flag.

Test Plan (CLK_DIV=4, DEPTH=16 unless noted):
- Single byte: reset, then i_we=1 with i_data=8'h41 for one cycle at edge 10.
  - o_tx from edge 11 in 4-cycle bits: 0, 1,0,0,0,0,0,1,0, 1.
  - Then idle high; o_busy falls at edge 51.
- Back-to-back: write 8'h55 then 8'hAA on consecutive cycles.
  - Two contiguous 40-cycle frames with no high gap between the stop and the second start bit.
  - o_level sequence is 1, 1, 0 around the pops.
- Overflow: 17 writes on consecutive cycles starting with the FSM IDLE.
  - The first write is popped; o_level settles at 15 then fills.
  - With 18 writes, o_full=1 and o_ovf=1.
  - The transmitted sequence omits only the dropped byte(s). o_ovf stays 1 after drain.
- Wrap-around: write 40 bytes 0..39, each written when o_full=0.
  - Decoded serial stream equals 0..39 in order; o_ovf stays 0.
- Reset mid-frame: assert i_rst for one cycle during DATA bit 3 with 5 bytes queued.
  - Next cycle: o_tx=1, o_level=0, o_busy=0, o_ovf=0.
  - A new write of 8'h7E transmits a clean frame.
- CLK_DIV=2: single byte 8'hFF gives o_tx 0 for 2 cycles, then 1 for 18 cycles.
